nec_frame_rx: RTL and testbench



---
 rtl/nec_rx_pkg.sv | 26 ++
 rtl/ir_in_sync.sv | 22 ++
 rtl/nec_frame_rx.sv | 117 +++++++++++
 tb/tb_nec_frame_rx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/nec_rx_pkg.sv
// nec_rx_pkg: FSM states, default NEC tick timings and frame field positions for nec_frame_rx
package nec_rx_pkg;
  typedef enum logic [2:0] {IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK} rxState_t;
  localparam int DEF_LEAD_MARK_MIN = 80;
  localparam int DEF_LEAD_MARK_MAX = 100;
  localparam int DEF_LEAD_SPACE_MIN = 40;
  localparam int DEF_LEAD_SPACE_MAX = 50;
  localparam int DEF_RPT_SPACE_MIN = 18;
  localparam int DEF_RPT_SPACE_MAX = 27;
  localparam int DEF_BIT_MARK_MIN = 3;
  localparam int DEF_BIT_MARK_MAX = 8;
  localparam int DEF_ZERO_MAX = 8;
  localparam int DEF_ONE_MIN = 14;
  localparam int DEF_ONE_MAX = 20;
  localparam int DEF_CNT_W = 7;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_N_LSB = 8;
  localparam int CMD_LSB = 16;
  localparam int CMD_N_LSB = 24;
  function automatic logic inWin(input int d, input int lo, input int hi);
    return d >= lo && d <= hi;
  endfunction
  function automatic logic complementOk(input logic [31:0] w);
    return w[ADDR_N_LSB +: 8] == ~w[ADDR_LSB +: 8] && w[CMD_N_LSB +: 8] == ~w[CMD_LSB +: 8];
  endfunction
endpackage

// File: rtl/ir_in_sync.sv
// ir_in_sync: two-flop synchronizer plus delayed copy; fall marks a mark start, rise a mark end
module ir_in_sync (
  input  logic CLK,
  input  logic RST,
  input  logic Din,
  output logic fall,
  output logic rise
);
  logic [1:0] syncReg;
  logic dly;
  always_ff @(posedge CLK) begin
    if (!RST) begin
      syncReg <= 2'b11;
      dly <= 1'b1;
    end else begin
      syncReg <= {syncReg[0], Din};
      dly <= syncReg[1];
    end
  end
  assign fall = dly & ~syncReg[1];
  assign rise = ~dly & syncReg[1];
endmodule

// File: rtl/nec_frame_rx.sv
// nec_frame_rx: NEC IR frame decoder; define NEC_CHECKSUM_EN to reject frames whose addr/cmd complements mismatch
module nec_frame_rx import nec_rx_pkg::*; #(
  parameter int LEAD_MARK_MIN = DEF_LEAD_MARK_MIN,
  parameter int LEAD_MARK_MAX = DEF_LEAD_MARK_MAX,
  parameter int LEAD_SPACE_MIN = DEF_LEAD_SPACE_MIN,
  parameter int LEAD_SPACE_MAX = DEF_LEAD_SPACE_MAX,
  parameter int RPT_SPACE_MIN = DEF_RPT_SPACE_MIN,
  parameter int RPT_SPACE_MAX = DEF_RPT_SPACE_MAX,
  parameter int BIT_MARK_MIN = DEF_BIT_MARK_MIN,
  parameter int BIT_MARK_MAX = DEF_BIT_MARK_MAX,
  parameter int ZERO_MAX = DEF_ZERO_MAX,
  parameter int ONE_MIN = DEF_ONE_MIN,
  parameter int ONE_MAX = DEF_ONE_MAX,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Din,
  output logic [31:0] Dout,
  output logic        Valid,
  output logic        Repeat,
  output logic        Err,
  output logic        Busy
);
  rxState_t state, nextState;
  logic fall, rise, sat, newBit, csPass, bad, vSet, rSet, eSet;
  logic [CNT_W-1:0] cnt;
  logic [4:0] bitIdx, nextIdx;
  logic [30:0] shiftReg, nextShift;
  logic [31:0] newWord;
  int dur;

  ir_in_sync uSync (.CLK(CLK), .RST(RST), .Din(Din), .fall(fall), .rise(rise));

  always_comb begin
    dur = int'(cnt);
    sat = &cnt;
    newBit = dur >= ONE_MIN;
    newWord = {newBit, shiftReg};
`ifdef NEC_CHECKSUM_EN
    csPass = complementOk(newWord);
`else
    csPass = 1'b1;
`endif
    nextState = state;
    nextIdx = bitIdx;
    nextShift = shiftReg;
    bad = 1'b0;
    vSet = 1'b0;
    rSet = 1'b0;
    eSet = 1'b0;
    case (state)
      IDLE: nextState = fall ? LEAD_MARK : IDLE;
      LEAD_MARK:
        if (rise) begin
          if (inWin(dur, LEAD_MARK_MIN, LEAD_MARK_MAX)) nextState = LEAD_SPACE;
          else bad = 1'b1;
        end else bad = sat;
      LEAD_SPACE:
        if (fall) begin
          if (inWin(dur, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
            nextIdx = '0;
            nextState = BIT_MARK;
          end else if (inWin(dur, RPT_SPACE_MIN, RPT_SPACE_MAX)) begin
            rSet = 1'b1;
            nextState = STOP_MARK;
          end else bad = 1'b1;
        end else bad = sat;
      BIT_MARK:
        if (rise) begin
          if (inWin(dur, BIT_MARK_MIN, BIT_MARK_MAX)) nextState = BIT_SPACE;
          else bad = 1'b1;
        end else bad = sat;
      BIT_SPACE:
        if (fall) begin
          if (inWin(dur, BIT_MARK_MIN, ZERO_MAX) || inWin(dur, ONE_MIN, ONE_MAX)) begin
            nextShift = newWord[31:1];
            nextIdx = bitIdx + 5'd1;
            // the fall after bit 31's space is the stop-mark start, so the frame commits here
            nextState = bitIdx == 5'd31 ? STOP_MARK : BIT_MARK;
            vSet = bitIdx == 5'd31 && csPass;
            eSet = bitIdx == 5'd31 && !csPass;
          end else bad = 1'b1;
        end else bad = sat;
      STOP_MARK: nextState = (rise || sat) ? IDLE : STOP_MARK;
      default: nextState = IDLE;
    endcase
    if (bad) begin
      eSet = 1'b1;
      nextState = fall ? LEAD_MARK : IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
      cnt <= '0;
      bitIdx <= '0;
      shiftReg <= '0;
      Dout <= '0;
      Valid <= 1'b0;
      Repeat <= 1'b0;
      Err <= 1'b0;
    end else begin
      state <= nextState;
      cnt <= (fall || rise) ? CNT_W'(1) : cnt + CNT_W'(!sat);
      bitIdx <= nextIdx;
      shiftReg <= nextShift;
      if (vSet) Dout <= newWord;
      Valid <= vSet;
      Repeat <= rSet;
      Err <= eSet;
    end
  end

  assign Busy = state != IDLE;
endmodule

// File: tb/tb_nec_frame_rx.sv
// tb_nec_frame_rx: randomized NEC frame stimulus with a queued scoreboard of expected strobes
module tb_nec_frame_rx;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic Din = 1'b1;
  logic [31:0] Dout;
  logic Valid, Repeat, Err, Busy;

  nec_frame_rx dut (.CLK(CLK), .RST(RST), .Din(Din), .Dout(Dout), .Valid(Valid),
                    .Repeat(Repeat), .Err(Err), .Busy(Busy));

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef enum {EV_VALID, EV_REPEAT, EV_ERR} ev_t;
  typedef struct {ev_t kind; logic [31:0] data; int at;} exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  logic [31:0] lastWord = '0;
  bit jitter = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (Valid || Repeat || Err) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: V=%b R=%b E=%b at cycle %0d, none expected", Valid, Repeat, Err, cyc);
      end else begin
        e = q.pop_front();
        check("strobe", {29'd0, Valid, Repeat, Err},
              e.kind == EV_VALID ? 32'd4 : e.kind == EV_REPEAT ? 32'd2 : 32'd1);
        check("dout", Dout, e.data);
        check("cycle", cyc, e.at);
      end
    end
  end

  // Each strobe is registered three edges after the Din change that caused it.
  task automatic pushExp(input ev_t k, input logic [31:0] d);
    q.push_back('{k, d, cyc + 3});
  endtask

  task automatic drive(input logic lvl, input int n);
    Din = lvl;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic int pick(input int nom, input int lo, input int hi);
    return jitter ? int'($urandom_range(hi, lo)) : nom;
  endfunction

  function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction

  function automatic bit commitOk(input logic [31:0] w);
`ifdef NEC_CHECKSUM_EN
    return w[15:8] == ~w[7:0] && w[31:24] == ~w[23:16];
`else
    return w != w + 32'd1;
`endif
  endfunction

  task automatic idle(input int n);
    drive(1'b1, n);
    check("busy_idle", Busy, 0);
  endtask

  // kind: 0 good, 1 bad space at bit `at`, 2 bad mark at bit `at`, 3 reset during bit `at`
  task automatic sendFrame(input logic [31:0] w, input int kind, input int at, input int badLen);
    int lm;
    lm = pick(90, 80, 100);
    drive(1'b0, 10);
    check("busy_lead", Busy, 1);
    drive(1'b0, lm - 10);
    drive(1'b1, pick(45, 40, 50));
    for (int i = 0; i < 32; i++) begin
      if (kind == 2 && i == at) begin
        drive(1'b0, badLen);
        pushExp(EV_ERR, lastWord);
        return;
      end
      if (kind == 3 && i == at) begin
        drive(1'b0, 4);
        RST = 1'b0;
        drive(1'b1, 3);
        RST = 1'b1;
        lastWord = '0;
        check("dout_after_reset", Dout, 0);
        check("busy_after_reset", Busy, 0);
        return;
      end
      drive(1'b0, pick(6, 3, 8));
      if (kind == 1 && i == at) begin
        drive(1'b1, badLen);
        pushExp(EV_ERR, lastWord);
        return;
      end
      drive(1'b1, w[i] ? pick(17, 14, 20) : pick(6, 3, 8));
    end
    if (commitOk(w)) begin
      pushExp(EV_VALID, w);
      lastWord = w;
    end else pushExp(EV_ERR, lastWord);
    drive(1'b0, pick(6, 3, 8));
  endtask

  task automatic sendRepeat();
    drive(1'b0, pick(90, 80, 100));
    drive(1'b1, pick(22, 18, 27));
    pushExp(EV_REPEAT, lastWord);
    drive(1'b0, pick(6, 3, 8));
  endtask

  task automatic badLead(input int len);
    drive(1'b0, len);
    pushExp(EV_ERR, lastWord);
  endtask

  // Leader followed by an over-long space: the counter reaches its 127 ceiling 127 ticks
  // after reloading at the detected rise, and the abort registers on the next edge.
  task automatic satSpace(input int len);
    drive(1'b0, pick(90, 80, 100));
    q.push_back('{EV_ERR, lastWord, cyc + 3 + 127});
    drive(1'b1, len);
  endtask

  initial begin
    int r;
    RST = 1'b0;
    Din = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    RST = 1'b1;
    check("rst_dout", Dout, 0);
    check("rst_strobes", {Valid, Repeat, Err}, 0);
    check("rst_busy", Busy, 0);
    idle(500);
    check("idle_dout", Dout, 0);

    sendFrame(mk(8'h00, 8'h45), 0, 0, 0);
    idle(30);
    check("nominal_dout", Dout, 32'hBA45FF00);
    sendRepeat();
    idle(30);
    check("repeat_dout", Dout, 32'hBA45FF00);
    badLead(60);
    idle(30);
    badLead(120);
    idle(200);
    satSpace(150);
    idle(30);
    check("abort_dout", Dout, 32'hBA45FF00);
    sendFrame(mk(8'h00, 8'h45), 1, 5, 11);
    sendFrame(mk(8'h00, 8'h46), 0, 0, 0);
    idle(30);
    sendFrame(mk(8'h21, 8'h07), 3, 20, 0);
    idle(30);
    sendFrame(mk(8'h12, 8'h34), 0, 0, 0);
    idle(30);
    sendFrame(32'h0045FF00, 0, 0, 0);
    idle(30);

    jitter = 1'b1;
    for (int n = 0; n < 30; n++) begin
      r = int'($urandom_range(9, 0));
      case (r)
        0, 1, 2, 3: sendFrame(mk(8'($urandom), 8'($urandom)), 0, 0, 0);
        4: sendFrame($urandom, 0, 0, 0);
        5: sendRepeat();
        6: badLead($urandom_range(1, 0) ? int'($urandom_range(79, 40)) : int'($urandom_range(126, 101)));
        7: begin
          sendFrame(mk(8'($urandom), 8'($urandom)), 1, int'($urandom_range(31, 0)),
                    $urandom_range(1, 0) ? int'($urandom_range(13, 9)) : int'($urandom_range(40, 21)));
          sendFrame(mk(8'($urandom), 8'($urandom)), 0, 0, 0);
        end
        8: sendFrame(mk(8'($urandom), 8'($urandom)), 2, int'($urandom_range(31, 0)),
                     int'($urandom_range(40, 9)));
        default: satSpace(int'($urandom_range(170, 135)));
      endcase
      idle(int'($urandom_range(60, 10)));
    end
    idle(200);
    check("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
